simmem_wresp_responder: RTL and testbench

//  Memory-side responder for the simulated-memory write channel: accepts write-address

---
 rtl/simmem_pkg.sv | 23 ++
 rtl/simmem_timed_fifo.sv | 80 ++++++++
 rtl/simmem_wresp_responder.sv | 57 +++++
 tb/tb_simmem_wresp_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared request/response types for the simulated-memory write path.
package simmem_pkg;

    localparam int unsigned IDWidth   = 4;
    localparam int unsigned AddrWidth = 32;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef struct packed {
        logic [IDWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } waddr_req_t;

    typedef struct packed {
        logic [IDWidth-1:0] id;
        logic [1:0]         rsp;
    } wresp_t;

endpackage

// File: rtl/simmem_timed_fifo.sv
// In-order FIFO whose entries become poppable only after a per-entry countdown expires.
module simmem_timed_fifo #(
    parameter int unsigned Depth   = 8,
    parameter int unsigned Latency = 4,
    parameter type         payload_t = logic
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  payload_t push_data_i,
    output logic     push_ready_o,
    input  logic     pop_i,
    output logic     head_valid_o,
    output payload_t head_data_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(Latency + 1);
    localparam logic [TmrW-1:0] TmrInit = TmrW'(Latency - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    payload_t        mem_q [Depth];
    logic [TmrW-1:0] tmr_q [Depth];
    logic [TmrW-1:0] tmr_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q;
    logic            push;
    logic            pop;

    // ready_q is registered, so a full FIFO refuses a push even while popping.
    assign push         = push_i & ready_q;
    assign pop          = pop_i & head_valid_o;
    assign push_ready_o = ready_q;
    assign head_valid_o = (cnt_q != '0) && (tmr_q[rd_ptr_q] == '0);
    assign head_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
        for (int unsigned i = 0; i < Depth; i++) begin
            tmr_d[i] = tmr_q[i];
            // Live when the entry's distance from head is below the occupancy.
            if (({1'b0, PtrW'(i) - rd_ptr_q} < cnt_q) && (tmr_q[i] != '0)) begin
                tmr_d[i] = tmr_q[i] - TmrW'(1);
            end
        end
        if (push) begin
            tmr_d[wr_ptr_q] = TmrInit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                tmr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= (cnt_d != CntFull);
            tmr_q    <= tmr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/simmem_wresp_responder.sv
// Memory-side write responder: one in-order response per request after a fixed latency.
// Define SIMMEM_WRESP_ERR_INJECT_EN to answer addresses >= ErrAddrBase with SLVERR.
module simmem_wresp_responder
    import simmem_pkg::*;
#(
    parameter int unsigned          Depth       = 8,
    parameter int unsigned          Latency     = 4,
    parameter logic [AddrWidth-1:0] ErrAddrBase = 32'h8000_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       waddr_valid_i,
    output logic       waddr_ready_o,
    input  waddr_req_t waddr_data_i,
    output logic       wresp_valid_o,
    input  logic       wresp_ready_i,
    output wresp_t     wresp_data_o
);

    wresp_t push_entry;
    wresp_t head_entry;
    logic   head_valid;
    logic   unused_fields;

    assign unused_fields = ^{waddr_data_i.addr, waddr_data_i.len, waddr_data_i.size,
                             waddr_data_i.burst, ErrAddrBase};

    always_comb begin
        push_entry     = '0;
        push_entry.id  = waddr_data_i.id;
        push_entry.rsp = RespOkay;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        if (waddr_data_i.addr >= ErrAddrBase) begin
            push_entry.rsp = RespSlvErr;
        end
`endif
    end

    simmem_timed_fifo #(
        .Depth     (Depth),
        .Latency   (Latency),
        .payload_t (wresp_t)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (waddr_valid_i),
        .push_data_i  (push_entry),
        .push_ready_o (waddr_ready_o),
        .pop_i        (wresp_ready_i),
        .head_valid_o (head_valid),
        .head_data_o  (head_entry)
    );

    assign wresp_valid_o = head_valid;
    assign wresp_data_o  = head_valid ? head_entry : '0;

endmodule

// File: tb/tb_simmem_wresp_responder.sv
// Scoreboard bench for simmem_wresp_responder (Depth 8, Latency 4).
module tb_simmem_wresp_responder;
    import simmem_pkg::*;

    localparam int unsigned Depth   = 8;
    localparam int unsigned Latency = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       waddr_valid_i = 1'b0;
    logic       waddr_ready_o;
    waddr_req_t waddr_data_i = '0;
    logic       wresp_valid_o;
    logic       wresp_ready_i = 1'b0;
    wresp_t     wresp_data_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned resp_cnt = 0;
    wresp_t      exp_q[$];
    logic        prev_hold = 1'b0;
    wresp_t      prev_data = '0;

    simmem_wresp_responder #(
        .Depth   (Depth),
        .Latency (Latency)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .waddr_valid_i (waddr_valid_i),
        .waddr_ready_o (waddr_ready_o),
        .waddr_data_i  (waddr_data_i),
        .wresp_valid_o (wresp_valid_o),
        .wresp_ready_i (wresp_ready_i),
        .wresp_data_o  (wresp_data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic wresp_t model(input waddr_req_t r);
        wresp_t e;
        e.id  = r.id;
        e.rsp = 2'b00;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        if (r.addr >= 32'h8000_0000) e.rsp = 2'b10;
`endif
        return e;
    endfunction

    // Monitor: inputs change at posedge+1, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!wresp_valid_o || wresp_data_o !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             wresp_valid_o, wresp_data_o, prev_data);
                end
            end
            if (wresp_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: id=%0d rsp=%0d, required no response",
                             wresp_data_o.id, wresp_data_o.rsp);
                end else if (wresp_data_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL resp_order: id=%0d rsp=%0d, required id=%0d rsp=%0d",
                             wresp_data_o.id, wresp_data_o.rsp, exp_q[0].id, exp_q[0].rsp);
                end
                if (wresp_ready_i) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    resp_cnt++;
                end
            end
            if (waddr_valid_i && waddr_ready_o) exp_q.push_back(model(waddr_data_i));
            prev_hold = wresp_valid_o && !wresp_ready_i;
            prev_data = wresp_data_o;
        end
    end

    // Holds waddr_valid_i high until accepted; returns the accepting edge's cycle number.
    task automatic send(input logic [IDWidth-1:0] id, input logic [AddrWidth-1:0] addr,
                        output int unsigned acc_cyc);
        logic        acc = 1'b0;
        int unsigned budget = 0;
        waddr_valid_i      = 1'b1;
        waddr_data_i.id    = id;
        waddr_data_i.addr  = addr;
        waddr_data_i.len   = 8'($urandom);
        waddr_data_i.size  = 3'($urandom);
        waddr_data_i.burst = 2'($urandom);
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = waddr_ready_o;
            @(posedge clk); #1;
            budget++;
        end
        acc_cyc = cyc;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b, required 1 within 200 cycles", waddr_ready_o);
        end
    endtask

    // Returns at the first negedge where wresp_valid_o is high.
    task automatic wait_valid(output int unsigned vc);
        int unsigned budget = 0;
        @(negedge clk);
        while (!wresp_valid_o && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        vc = cyc;
        if (!wresp_valid_o) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: valid=%b, required 1 within 100 cycles",
                     wresp_valid_o);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (waddr_ready_o !== 1'b0 || wresp_valid_o !== 1'b0 || wresp_data_o !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h, required 0 0 0",
                     waddr_ready_o, wresp_valid_o, wresp_data_o);
        end
        rst_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (waddr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b, required 1", waddr_ready_o);
        end
    endtask

    task automatic test_single();
        int unsigned acc, vc;
        wresp_ready_i = 1'b1;
        send(4'd3, 32'h10, acc);
        waddr_valid_i = 1'b0;
        wait_valid(vc);
        // Response handshakes on edge vc+1; that must be Latency edges after acceptance.
        checks++;
        if (vc + 1 - acc != Latency) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required %0d", vc + 1 - acc, Latency);
        end
        checks++;
        if (wresp_data_o.id !== 4'd3 || wresp_data_o.rsp !== 2'b00) begin
            errors++;
            $display("FAIL single_data: id=%0d rsp=%0d, required id=3 rsp=0",
                     wresp_data_o.id, wresp_data_o.rsp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        int unsigned acc;
        wresp_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send(IDWidth'(i), AddrWidth'(i * 16), acc);
        waddr_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (waddr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready: ready=%b, required 0 when full", waddr_ready_o);
        end
        repeat (Latency) begin @(posedge clk); #1; end
        wresp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (wresp_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL drain_gap: beat %0d valid=%b, required 1", i, wresp_valid_o);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (wresp_valid_o !== 1'b0 || waddr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: valid=%b ready=%b, required 0 1",
                     wresp_valid_o, waddr_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int unsigned acc, vc;
        wresp_t held;
        wresp_ready_i = 1'b0;
        send(4'd5, 32'h20, acc);
        waddr_valid_i = 1'b0;
        wait_valid(vc);
        held = wresp_data_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (wresp_valid_o !== 1'b1 || wresp_data_o !== held || held.id !== 4'd5) begin
                errors++;
                $display("FAIL hold_resp: valid=%b id=%0d, required valid=1 id=5",
                         wresp_valid_o, wresp_data_o.id);
            end
        end
        @(posedge clk); #1;
        wresp_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wresp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b, required 0", wresp_valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_push_pop();
        int unsigned acc, r0;
        wresp_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send(IDWidth'(i + 1), AddrWidth'(i), acc);
        waddr_valid_i = 1'b0;
        repeat (Latency) begin @(posedge clk); #1; end
        waddr_valid_i   = 1'b1;
        waddr_data_i.id = 4'd12;
        wresp_ready_i   = 1'b1;
        r0 = resp_cnt;
        @(negedge clk);
        checks++;
        if (waddr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: ready=%b, required 0", waddr_ready_o);
        end
        @(posedge clk); #1;
        waddr_valid_i = 1'b0;
        wresp_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (waddr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_count7: ready=%b, required 1 after pop", waddr_ready_o);
        end
        @(posedge clk); #1;
        wresp_ready_i = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        checks++;
        if (resp_cnt - r0 != 8) begin
            errors++;
            $display("FAIL full_total: %0d responses, required 8", resp_cnt - r0);
        end
    endtask

    task automatic test_reset_flush();
        int unsigned acc, r0;
        wresp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(IDWidth'(i + 9), AddrWidth'(i), acc);
        waddr_valid_i = 1'b0;
        repeat (Latency + 1) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (waddr_ready_o !== 1'b0 || wresp_valid_o !== 1'b0 || wresp_data_o !== '0) begin
            errors++;
            $display("FAIL flush_reset: ready=%b valid=%b data=%h, required 0 0 0",
                     waddr_ready_o, wresp_valid_o, wresp_data_o);
        end
        rst_i = 1'b0;
        wresp_ready_i = 1'b1;
        r0 = resp_cnt;
        @(posedge clk); #1;
        checks++;
        if (waddr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: ready=%b, required 1", waddr_ready_o);
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (resp_cnt != r0) begin
            errors++;
            $display("FAIL flush_silent: %0d responses, required 0", resp_cnt - r0);
        end
    endtask

    task automatic test_err_inject();
        int unsigned acc, vc;
        logic [1:0] exp_rsp;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        exp_rsp = 2'b10;
`else
        exp_rsp = 2'b00;
`endif
        wresp_ready_i = 1'b0;
        send(4'd1, 32'h8000_0010, acc);
        send(4'd2, 32'h0000_0010, acc);
        waddr_valid_i = 1'b0;
        wait_valid(vc);
        checks++;
        if (wresp_data_o.id !== 4'd1 || wresp_data_o.rsp !== exp_rsp) begin
            errors++;
            $display("FAIL err_high: id=%0d rsp=%0d, required id=1 rsp=%0d",
                     wresp_data_o.id, wresp_data_o.rsp, exp_rsp);
        end
        @(posedge clk); #1;
        wresp_ready_i = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_back_to_back();
        int unsigned budget = 0;
        fork
            begin
                int unsigned acc;
                for (int i = 0; i < 16; i++) begin
                    send(IDWidth'($urandom), {1'($urandom), 31'($urandom)}, acc);
                end
                waddr_valid_i = 1'b0;
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    wresp_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        wresp_ready_i = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_hold();
        test_full_push_pop();
        test_reset_flush();
        test_err_inject();
        test_back_to_back();
        repeat (3) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
